// File: rtl/tb_wait_event_ctrl.sv
// rtl/tb_wait_event_ctrl.sv - wait-event responder for the sequencer WAIT command path
// Optional timeout support is enabled by defining TB_WAIT_EVT_TIMEOUT_EN.
module tb_wait_event_ctrl #(
    parameter int WAIT_ALIAS_NB = 5,
    parameter int SEL_WIDTH     = 3,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WAIT_ALIAS_NB-1:0] i_wait,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [SEL_WIDTH-1:0]     i_cmd_sel,
    input  logic [2:0]               i_cmd_type,
    input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
    input  logic                     i_abort,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_status,
    output logic [TIMEOUT_WIDTH-1:0] o_elapsed
);

    localparam int SEL_NB = 2 ** SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] ALIAS_NB_W = (SEL_WIDTH + 1)'(WAIT_ALIAS_NB);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_ABORT   = 2'b10;
    localparam logic [1:0] STATUS_BAD_CMD = 2'b11;

    localparam logic [2:0] TYPE_RISE = 3'd0;
    localparam logic [2:0] TYPE_FALL = 3'd1;
    localparam logic [2:0] TYPE_ANY  = 3'd2;
    localparam logic [2:0] TYPE_HIGH = 3'd3;
    localparam logic [2:0] TYPE_LOW  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                     state_q;
    logic [WAIT_ALIAS_NB-1:0]   prev_q;
    logic [SEL_WIDTH-1:0]       sel_q;
    logic [2:0]                 type_q;
    logic [TIMEOUT_WIDTH-1:0]   timeout_q;
    logic [TIMEOUT_WIDTH-1:0]   elapsed_q;
    logic [TIMEOUT_WIDTH-1:0]   elapsed_d;
    logic                       done_q;
    logic [1:0]                 status_q;
    logic [TIMEOUT_WIDTH-1:0]   elapsed_out_q;

    logic [SEL_NB-1:0]          cur_ext;
    logic [SEL_NB-1:0]          prev_ext;
    logic                       cur_bit;
    logic                       prev_bit;
    logic                       match_hit;
    logic                       timeout_hit;
    logic                       cmd_bad;

    // Widen to a full power-of-two vector so any sel value indexes safely.
    assign cur_ext  = SEL_NB'(i_wait);
    assign prev_ext = SEL_NB'(prev_q);
    assign cur_bit  = cur_ext[sel_q];
    assign prev_bit = prev_ext[sel_q];

    always_comb begin
        match_hit = 1'b0;
        case (type_q)
            TYPE_RISE: match_hit = cur_bit & ~prev_bit;
            TYPE_FALL: match_hit = ~cur_bit & prev_bit;
            TYPE_ANY:  match_hit = cur_bit ^ prev_bit;
            TYPE_HIGH: match_hit = cur_bit;
            TYPE_LOW:  match_hit = ~cur_bit;
            default:   match_hit = 1'b0;
        endcase
    end

`ifdef TB_WAIT_EVT_TIMEOUT_EN
    assign timeout_hit = (timeout_q != '0) && (elapsed_q == timeout_q - 1'b1);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_q;
    assign timeout_hit    = 1'b0;
`endif

    assign elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
    assign cmd_bad   = (i_cmd_type > TYPE_LOW) || ({1'b0, i_cmd_sel} >= ALIAS_NB_W);

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_elapsed   = elapsed_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prev_q        <= '0;
            sel_q         <= '0;
            type_q        <= '0;
            timeout_q     <= '0;
            elapsed_q     <= '0;
            done_q        <= 1'b0;
            status_q      <= STATUS_OK;
            elapsed_out_q <= '0;
        end else begin
            prev_q <= i_wait;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        sel_q     <= i_cmd_sel;
                        type_q    <= i_cmd_type;
                        timeout_q <= i_cmd_timeout;
                        elapsed_q <= '0;
                        if (cmd_bad) begin
                            state_q       <= ST_DONE;
                            done_q        <= 1'b1;
                            status_q      <= STATUS_BAD_CMD;
                            elapsed_out_q <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (match_hit) begin
                        state_q       <= ST_DONE;
                        done_q        <= 1'b1;
                        status_q      <= STATUS_OK;
                        elapsed_out_q <= elapsed_q;
                    end else if (i_abort) begin
                        state_q       <= ST_DONE;
                        done_q        <= 1'b1;
                        status_q      <= STATUS_ABORT;
                        elapsed_out_q <= elapsed_q;
                    end else if (timeout_hit) begin
                        state_q       <= ST_DONE;
                        done_q        <= 1'b1;
                        status_q      <= STATUS_TIMEOUT;
                        elapsed_out_q <= timeout_q;
                    end else begin
                        elapsed_q <= elapsed_d;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_wait_event_ctrl.sv
// tb/tb_tb_wait_event_ctrl.sv - directed bench for tb_wait_event_ctrl
module tb_tb_wait_event_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  i_wait = '0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_sel = '0;
    logic [2:0]  i_cmd_type = '0;
    logic [31:0] i_cmd_timeout = '0;
    logic        i_abort = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_status;
    logic [31:0] o_elapsed;

    int checks = 0;
    int errors = 0;

    tb_wait_event_ctrl #(
        .WAIT_ALIAS_NB(5),
        .SEL_WIDTH(3),
        .TIMEOUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_wait(i_wait),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_sel(i_cmd_sel),
        .i_cmd_type(i_cmd_type),
        .i_cmd_timeout(i_cmd_timeout),
        .i_abort(i_abort),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_status(o_status),
        .o_elapsed(o_elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command for one cycle; returns in WAIT cycle 0 (or DONE for bad commands).
    task automatic issue(input logic [2:0] sel, input logic [2:0] typ, input logic [31:0] tmo);
        check("ready_before_cmd", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid   = 1'b1;
        i_cmd_sel     = sel;
        i_cmd_type    = typ;
        i_cmd_timeout = tmo;
        step(1);
        i_cmd_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [1:0] st, input logic [31:0] el);
        check({tag, "_done"}, {31'd0, o_done}, 32'd1);
        check({tag, "_status"}, {30'd0, o_status}, {30'd0, st});
        check({tag, "_elapsed"}, o_elapsed, el);
        check({tag, "_ready_low"}, {31'd0, o_cmd_ready}, 32'd0);
    endtask

    logic seen_done;

    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_status", {30'd0, o_status}, 32'd0);
        check("rst_elapsed", o_elapsed, 32'd0);

        // RISE on sel 2, edge in WAIT cycle 10
        issue(3'd2, 3'd0, 32'd100);
        check("rise_busy", {31'd0, o_busy}, 32'd1);
        step(10);
        i_wait[2] = 1'b1;
        check("rise_no_early_done", {31'd0, o_done}, 32'd0);
        step(1);
        expect_done("rise", 2'b00, 32'd10);
        step(1);
        check("rise_ready_after", {31'd0, o_cmd_ready}, 32'd1);
        check("rise_done_cleared", {31'd0, o_done}, 32'd0);
        check("rise_elapsed_held", o_elapsed, 32'd10);

        // HIGH on a level already present
        i_wait = 5'b00001;
        step(2);
        issue(3'd0, 3'd3, 32'd0);
        step(1);
        expect_done("high", 2'b00, 32'd0);
        step(1);

        // RISE with no edge and timeout 8
        issue(3'd0, 3'd0, 32'd8);
        step(7);
        check("tmo_no_early_done", {31'd0, o_done}, 32'd0);
        step(1);
`ifdef TB_WAIT_EVT_TIMEOUT_EN
        expect_done("tmo", 2'b01, 32'd8);
`else
        check("tmo_disabled_no_done", {31'd0, o_done}, 32'd0);
        i_abort = 1'b1;
        step(1);
        i_abort = 1'b0;
        expect_done("tmo_dis_abort", 2'b10, 32'd8);
`endif
        step(1);

        // ANY with abort at WAIT cycle 5
        issue(3'd1, 3'd2, 32'd0);
        step(5);
        i_abort = 1'b1;
        step(1);
        i_abort = 1'b0;
        expect_done("abort", 2'b10, 32'd5);
        step(1);

        // FALL and abort together: match wins
        i_wait[1] = 1'b1;
        step(2);
        issue(3'd1, 3'd1, 32'd0);
        step(2);
        i_wait[1] = 1'b0;
        i_abort   = 1'b1;
        step(1);
        i_abort = 1'b0;
        expect_done("fall_vs_abort", 2'b00, 32'd2);
        step(1);

        // bad type and bad sel
        issue(3'd0, 3'd6, 32'd0);
        expect_done("bad_type", 2'b11, 32'd0);
        step(1);
        check("bad_type_ready_after", {31'd0, o_cmd_ready}, 32'd1);
        issue(3'd7, 3'd0, 32'd0);
        expect_done("bad_sel", 2'b11, 32'd0);
        step(1);

        // reset mid-WAIT
        i_wait = 5'b00000;
        step(1);
        issue(3'd3, 3'd0, 32'd0);
        step(3);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("midrst_status", {30'd0, o_status}, 32'd0);
        check("midrst_elapsed", o_elapsed, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen_done = seen_done | o_done;
        end
        rst = 1'b0;
        step(1);
        seen_done = seen_done | o_done;
        check("midrst_no_done", {31'd0, seen_done}, 32'd0);

        // LOW on sel 4 after reset
        issue(3'd4, 3'd4, 32'd0);
        step(1);
        expect_done("low", 2'b00, 32'd0);
        step(1);

        // RISE with timeout 4 and no edge for 50 cycles
        issue(3'd3, 3'd0, 32'd4);
`ifdef TB_WAIT_EVT_TIMEOUT_EN
        step(4);
        expect_done("tmo4", 2'b01, 32'd4);
        step(1);
`else
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            seen_done = seen_done | o_done;
            step(1);
        end
        check("long_wait_no_done", {31'd0, seen_done | o_done}, 32'd0);
        i_abort = 1'b1;
        step(1);
        i_abort = 1'b0;
        expect_done("long_abort", 2'b10, 32'd50);
        step(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
